// File: rtl/l1i_mau.sv
// l1i_mau: L1 instruction-cache miss access unit.
// Refills one cache line by issuing sequential word reads to memory,
// one request outstanding at a time, then pulses an ack with the full line.
// Optional feature macro: L1I_MAU_LINE_BUF_EN keeps the last delivered line
// and its base address so a repeat request is answered without a memory fetch.

module l1i_mau #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 128,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mau_req_val,
    input  logic [ADDR_WIDTH-1:0] mau_req_addr,
    output logic                  mau_req_ack,
    output logic [LINE_SIZE-1:0]  mau_ack_data,
    output logic                  mem_req_val,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ack,
    input  logic                  mem_rsp_val,
    input  logic [BUS_WIDTH-1:0]  mem_rsp_data
);

    localparam int WORDS       = LINE_SIZE / BUS_WIDTH;
    localparam int CNT_W       = $clog2(WORDS);
    localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
    localparam int BYTE_SHIFT  = $clog2(BUS_WIDTH / 8);

    // Byte-offset bits inside a line; cleared to form the line base address.
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LINE_SIZE-1:0]  r_line;
    logic                  r_ack;
    logic                  r_mem_req_val;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;

    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [CNT_W-1:0]      w_next_cnt;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_last;
    logic                  w_hit;

    assign w_aligned   = mau_req_addr & ~OFFSET_MASK;
    assign w_next_cnt  = r_cnt + 1'b1;
    assign w_next_addr = r_base + (ADDR_WIDTH'(w_next_cnt) << BYTE_SHIFT);
    assign w_last      = (r_cnt == CNT_W'(WORDS - 1));

`ifdef L1I_MAU_LINE_BUF_EN
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic                  r_buf_valid;

    assign w_hit = r_buf_valid && (r_buf_addr == w_aligned);

    // Remember the base address of every line delivered; the line itself stays in r_line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_addr  <= '0;
            r_buf_valid <= 1'b0;
        end else if (r_state == S_ACK) begin
            r_buf_addr  <= r_base;
            r_buf_valid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Refill FSM; every output comes straight from a register set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_base         <= '0;
            r_line         <= '0;
            r_ack          <= 1'b0;
            r_mem_req_val  <= 1'b0;
            r_mem_req_addr <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mau_req_val) begin
                        r_base <= w_aligned;
                        r_cnt  <= '0;
                        if (w_hit) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state        <= S_REQ;
                            r_mem_req_val  <= 1'b1;
                            r_mem_req_addr <= w_aligned;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ack) begin
                        r_mem_req_val <= 1'b0;
                        r_state       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (mem_rsp_val) begin
                        for (int w = 0; w < WORDS; w++) begin
                            if (r_cnt == CNT_W'(w)) begin
                                r_line[w*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_cnt          <= w_next_cnt;
                            r_mem_req_val  <= 1'b1;
                            r_mem_req_addr <= w_next_addr;
                            r_state        <= S_REQ;
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mau_req_ack  = r_ack;
    assign mau_ack_data = r_line;
    assign mem_req_val  = r_mem_req_val;
    assign mem_req_addr = r_mem_req_addr;

endmodule

// File: tb/tb_l1i_mau.sv
// tb_l1i_mau: directed table-driven bench for l1i_mau with a behavioural
// word memory. Define L1I_MAU_LINE_BUF_EN to exercise the line-buffer hit path.

module tb_l1i_mau;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mau_req_val = 1'b0;
    logic [31:0]  mau_req_addr = '0;
    logic         mau_req_ack;
    logic [127:0] mau_ack_data;
    logic         mem_req_val;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ack = 1'b0;
    logic         mem_rsp_val = 1'b0;
    logic [31:0]  mem_rsp_data = '0;

    int assertCount = 0;
    int failCount = 0;

    l1i_mau #(
        .ADDR_WIDTH(32),
        .LINE_SIZE (128),
        .BUS_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mau_req_val (mau_req_val),
        .mau_req_addr(mau_req_addr),
        .mau_req_ack (mau_req_ack),
        .mau_ack_data(mau_ack_data),
        .mem_req_val (mem_req_val),
        .mem_req_addr(mem_req_addr),
        .mem_req_ack (mem_req_ack),
        .mem_rsp_val (mem_rsp_val),
        .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    // Memory contents: line 0x100 holds 0x11,0x22,0x33,0x44; elsewhere C0DE plus low address bits.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model state; the knobs below are written only by the main test.
    int          ackDelay [4];
    int          injectReq = 0;
    logic [31:0] injectData = '0;
    int          strayReq = 0;

    int          injectDone = 0;
    int          strayDone = 0;
    int          waitCount = 0;
    bit          rspPending = 1'b0;
    logic [31:0] rspData = '0;
    bit          holding = 1'b0;
    logic [31:0] holdAddr = '0;
    int          holdLen [4];
    int          reqValCycles = 0;
    int          unstable = 0;
    int          overlapErr = 0;
    logic [31:0] acceptedAddr [$];

    // Behavioural memory: acks after ackDelay[word] wait cycles, responds the cycle after the ack.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            waitCount    = 0;
            rspPending   = 1'b0;
            holding      = 1'b0;
            mem_req_ack  = 1'b0;
            mem_rsp_val  = 1'b0;
            mem_rsp_data = '0;
        end else begin
            if (mem_req_val && rspPending) overlapErr++;
            mem_req_ack  = 1'b0;
            mem_rsp_val  = 1'b0;
            mem_rsp_data = '0;
            if (rspPending) begin
                mem_rsp_val  = 1'b1;
                mem_rsp_data = rspData;
                rspPending   = 1'b0;
            end else if (injectReq != injectDone) begin
                mem_rsp_val  = 1'b1;
                mem_rsp_data = injectData;
                injectDone++;
            end
            if (mem_req_val) begin
                reqValCycles++;
                if (!holding) begin
                    holding   = 1'b1;
                    holdAddr  = mem_req_addr;
                    waitCount = 0;
                end else if (mem_req_addr != holdAddr) begin
                    unstable++;
                end
                if (waitCount < ackDelay[mem_req_addr[3:2]]) begin
                    waitCount++;
                    if (strayReq != strayDone && !mem_rsp_val) begin
                        mem_rsp_val  = 1'b1;
                        mem_rsp_data = 32'h0000_BEEF;
                        strayDone++;
                    end
                end else begin
                    mem_req_ack = 1'b1;
                    rspPending  = 1'b1;
                    rspData     = memWord(mem_req_addr);
                    holdLen[mem_req_addr[3:2]] = waitCount + 1;
                    acceptedAddr.push_back(mem_req_addr);
                    holding = 1'b0;
                end
            end
        end
    end

    int           ackCount = 0;
    logic [127:0] lastAckData = '0;

    // Count ack pulses and capture the line delivered with each one.
    always @(negedge clk) begin
        if (mau_req_ack) begin
            ackCount++;
            lastAckData = mau_ack_data;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Issue one request and report latency counting the request cycle as cycle 1.
    task automatic applyStimulus(input logic [31:0] addr, input string name, output int lat);
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mau_req_val  = 1'b1;
        mau_req_addr = addr;
        lat  = 1;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            mau_req_val = 1'b0;
            lat++;
            if (mau_req_ack) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_ack_seen"}, 128'(seen), 128'd1);
    endtask

    typedef struct {
        logic [31:0]  reqAddr;
        int           ackDelay1;
        logic [127:0] expLine;
        logic [31:0]  expFirst;
        int           expLatency;
    } vector_t;

    vector_t vectors [5];

    initial begin
        int lat;
        int accBase;
        int ackBase;
        int valBase;
        bit found;
        string nm;

        vectors[0] = '{32'h0000_0100, 0, 128'h00000044_00000033_00000022_00000011, 32'h0000_0100, 10};
        vectors[1] = '{32'h0000_0100, 3, 128'h00000044_00000033_00000022_00000011, 32'h0000_0100, 13};
        vectors[2] = '{32'h0000_010C, 0, 128'h00000044_00000033_00000022_00000011, 32'h0000_0100, 10};
        vectors[3] = '{32'h0000_0200, 0, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200, 32'h0000_0200, 10};
        vectors[4] = '{32'hFFFF_FFF4, 0, 128'hC0DEFFFC_C0DEFFF8_C0DEFFF4_C0DEFFF0, 32'hFFFF_FFF0, 10};

        for (int k = 0; k < 4; k++) ackDelay[k] = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ack", 128'(mau_req_ack), 128'd0);
        checkOutput("reset_data", mau_ack_data, 128'd0);
        checkOutput("reset_mem_val", 128'(mem_req_val), 128'd0);
        checkOutput("reset_mem_addr", 128'(mem_req_addr), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            resetDut();
            ackDelay[1] = vectors[i].ackDelay1;
            accBase = acceptedAddr.size();
            ackBase = ackCount;
            nm = $sformatf("v%0d", i);
            applyStimulus(vectors[i].reqAddr, nm, lat);
            repeat (3) @(posedge clk);
            #1;
            checkOutput({nm, "_latency"}, 128'(lat), 128'(vectors[i].expLatency));
            checkOutput({nm, "_line"}, lastAckData, vectors[i].expLine);
            checkOutput({nm, "_ack_pulses"}, 128'(ackCount - ackBase), 128'd1);
            checkOutput({nm, "_num_reads"}, 128'(acceptedAddr.size() - accBase), 128'd4);
            if (acceptedAddr.size() - accBase == 4) begin
                for (int w = 0; w < 4; w++) begin
                    checkOutput($sformatf("%s_addr%0d", nm, w), 128'(acceptedAddr[accBase + w]),
                                128'(vectors[i].expFirst + 32'(4 * w)));
                end
            end
            checkOutput({nm, "_word1_hold"}, 128'(holdLen[1]), 128'(vectors[i].ackDelay1 + 1));
            ackDelay[1] = 0;
        end

        // Reset in the middle of a refill (after word 1's response) abandons it.
        resetDut();
        ackBase = ackCount;
        @(negedge clk);
        mau_req_val  = 1'b1;
        mau_req_addr = 32'h0000_0100;
        @(posedge clk);
        #1;
        mau_req_val = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (mem_req_val && mem_req_addr == 32'h0000_0108) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rst_mid_reached_word2", 128'(found), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ack", 128'(mau_req_ack), 128'd0);
        checkOutput("rst_mid_data", mau_ack_data, 128'd0);
        checkOutput("rst_mid_mem_val", 128'(mem_req_val), 128'd0);
        checkOutput("rst_mid_mem_addr", 128'(mem_req_addr), 128'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_ack", 128'(ackCount - ackBase), 128'd0);
        checkOutput("rst_mid_idle", 128'(mem_req_val), 128'd0);
        applyStimulus(32'h0000_0200, "after_rst", lat);
        repeat (2) @(posedge clk);
        checkOutput("after_rst_latency", 128'(lat), 128'd10);
        checkOutput("after_rst_line", lastAckData, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);

        // Stray responses in IDLE and in REQ must be ignored.
        resetDut();
        injectData = 32'h0000_DEAD;
        injectReq++;
        repeat (3) @(posedge clk);
        ackDelay[0] = 2;
        strayReq++;
        ackBase = ackCount;
        applyStimulus(32'h0000_0100, "stray", lat);
        repeat (2) @(posedge clk);
        checkOutput("stray_latency", 128'(lat), 128'd12);
        checkOutput("stray_line", lastAckData, 128'h00000044_00000033_00000022_00000011);
        checkOutput("stray_ack_pulses", 128'(ackCount - ackBase), 128'd1);
        ackDelay[0] = 0;

`ifdef L1I_MAU_LINE_BUF_EN
        // Repeat request hits the retained line; a different line goes to memory.
        resetDut();
        applyStimulus(32'h0000_0100, "buf_first", lat);
        checkOutput("buf_first_latency", 128'(lat), 128'd10);
        valBase = reqValCycles;
        applyStimulus(32'h0000_0100, "buf_hit", lat);
        repeat (2) @(posedge clk);
        checkOutput("buf_hit_latency", 128'(lat), 128'd2);
        checkOutput("buf_hit_no_mem", 128'(reqValCycles - valBase), 128'd0);
        checkOutput("buf_hit_line", lastAckData, 128'h00000044_00000033_00000022_00000011);
        accBase = acceptedAddr.size();
        applyStimulus(32'h0000_0200, "buf_miss", lat);
        repeat (2) @(posedge clk);
        checkOutput("buf_miss_latency", 128'(lat), 128'd10);
        checkOutput("buf_miss_reads", 128'(acceptedAddr.size() - accBase), 128'd4);
        checkOutput("buf_miss_line", lastAckData, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);
`else
        // Without the line buffer a repeated request is fetched again.
        resetDut();
        applyStimulus(32'h0000_0100, "nobuf_first", lat);
        valBase = reqValCycles;
        applyStimulus(32'h0000_0100, "nobuf_again", lat);
        repeat (2) @(posedge clk);
        checkOutput("nobuf_again_latency", 128'(lat), 128'd10);
        checkOutput("nobuf_again_mem_cycles", 128'(reqValCycles - valBase), 128'd4);
        checkOutput("nobuf_again_line", lastAckData, 128'h00000044_00000033_00000022_00000011);
`endif

        checkOutput("one_outstanding", 128'(overlapErr), 128'd0);
        checkOutput("req_addr_stable", 128'(unstable), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
